store_size_ctrl: RTL and testbench
==================================

Name: store_size_ctrl

Overview:
- Store-side counterpart of the load-size/extend path in the multicycle MIPS datapath.
- Writes a word, halfword or byte from register B into byte-addressed memory (sw/sh/sb).
- sw is written directly. sh/sb use a read-modify-write sequence on the aligned memory word so the other byte lanes are preserved.
- Sits between the control unit (start/op) and the memory write-data/write-enable ports.

Parameters:
- ADDR_W, 32, address width.
- WAIT_CYCLES, 1, cycles between presenting a read address and mem_rdata being valid; range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- ss_op  in  2  00=sw, 01=sh, 10=sb, 11=illegal.
- addr  in  ADDR_W  byte address from ALUOut.
- reg_data  in  32  store data (register B).
- mem_rdata  in  32  memory read data.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  merged write data.
- mem_wr  out  1  memory write enable.
- busy  out  1  high from RD through WR.
- done  out  1  one-cycle pulse when the store completes.
- misaligned  out  1  one-cycle pulse on an illegal or misaligned request.

Behaviour:
- The interface uses one clock (clk). reset is synchronous and active-high.
- Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, misaligned=0, wait counter=0. Reset overrides everything, including an operation in progress.
- Capture: on a start edge in IDLE, latch ss_op, addr and reg_data. start outside IDLE is ignored, with no queuing.
- Memory layout: little-endian. Lane n = bits 8n+7:8n, selected by addr[1:0].
- Error check at capture:
  - ss_op=11 → error.
  - sw with addr[1:0]≠00 → error.
  - sh with addr[0]=1 → error.
  - On error: next state ERR.
- States:
  - IDLE: outputs 0. start & error → ERR. start & sw → WR. start & (sh|sb) → RD.
  - RD: mem_addr driven, mem_wr=0, busy=1. Load wait counter with WAIT_CYCLES-1. → WT.
  - WT: busy=1. Count down each cycle. When counter=0, capture mem_rdata into the read buffer → WR.
  - WR: mem_wr=1 for exactly one cycle, busy=1. mem_wdata is:
    - sw: reg_data.
    - sh: read buffer with the halfword at lane pair addr[1] replaced by reg_data[15:0].
    - sb: read buffer with lane addr[1:0] replaced by reg_data[7:0].
    - → FIN.
  - FIN: done=1, busy=0 → IDLE.
  - ERR: misaligned=1, done=0, mem_wr=0 → IDLE.
- Output timing: mem_wr, busy, done and misaligned are decoded from the registered state only, so they are glitch-free. mem_addr and mem_wdata hold their values from RD through FIN.
- Latency (start edge = cycle 0):
  - sw: WR in cycle 1, done in cycle 2.
  - sh/sb: RD in 1, WT in 2..1+WAIT_CYCLES, WR in 2+WAIT_CYCLES, done in 3+WAIT_CYCLES.
  - Error: misaligned in cycle 1.
- Back-to-back: a start asserted in the FIN cycle is ignored. The next request is accepted in IDLE, the cycle after FIN.
- Reset in RD/WT/WR: next cycle is IDLE, with mem_wr=0, done=0 and no write issued after the reset edge.
- mem_rdata is ignored outside the final WT cycle.

Test Plan:
- sb addr=0x00000102, reg_data=0x123456AB, memory word 0xDEADBEEF, WAIT_CYCLES=1 → single mem_wr pulse in cycle 3, mem_addr=0x00000100, mem_wdata=0xDEABBEEF, done in cycle 4.
- sh at addr=0x104, then at addr=0x106, reg_data=0x0000CAFE, memory 0x11223344 → writes 0x1122CAFE and 0xCAFE3344 respectively; start pulsed during busy is ignored (exactly two writes total).
- sw addr=0x108, reg_data=0x89ABCDEF → mem_wr in cycle 1 with mem_wdata=0x89ABCDEF, no RD/WT cycles, done in cycle 2.
- sw addr=0x10A; sh addr=0x101; ss_op=11 → each gives misaligned=1 in cycle 1, done=0, mem_wr never asserted.
- WAIT_CYCLES=3, sb addr=0x103, reg_data=0xFF, memory 0x00000000 → mem_rdata sampled after 3 WT cycles; write 0xFF000000 in cycle 5, done in cycle 6.
- reset asserted during WT of an sb → next cycle IDLE with all outputs 0, no mem_wr pulse; a subsequent start behaves normally.

Source files
------------

// File: rtl/store_size_ctrl.sv
// store_size_ctrl: sw/sh/sb store path; sub-word stores read-modify-write the aligned word.
module store_size_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        ss_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       reg_data,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              misaligned
);
  typedef enum logic [2:0] {IDLE, RD, WT, WR, FIN, ERR} state_t;
  state_t state, nxt;
  logic [1:0]        op;
  logic [ADDR_W-1:0] a;
  logic [15:0]       d;
  logic [31:0]       wd, half, byte_m, merged;
  logic [2:0]        cnt;
  logic [4:0]        sh;
  logic              err, act;
  assign err = ss_op == 2'b11 || (ss_op == 2'b00 && addr[1:0] != 2'b00) || (ss_op == 2'b01 && addr[0]);
  assign sh = {a[1:0], 3'b000};
  assign half = a[1] ? {d, mem_rdata[15:0]} : {mem_rdata[31:16], d};
  assign byte_m = (mem_rdata & ~(32'hFF << sh)) | ({24'b0, d[7:0]} << sh);
  assign merged = op == 2'b01 ? half : byte_m;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !start ? IDLE : err ? ERR : ss_op == 2'b00 ? WR : RD;
      RD:   nxt = WT;
      WT:   nxt = cnt == 3'd0 ? WR : WT;
      WR:   nxt = FIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= 2'b00;
      a     <= '0;
      d     <= 16'h0;
      wd    <= 32'h0;
      cnt   <= 3'd0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        op <= ss_op;
        a  <= addr;
        d  <= reg_data[15:0];
        wd <= reg_data;
      end
      if (state == RD) cnt <= 3'(WAIT_CYCLES - 1);
      else if (state == WT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == WT && cnt == 3'd0) wd <= merged;
    end
  end
  assign act        = state == RD || state == WT || state == WR || state == FIN;
  assign mem_addr   = act ? {a[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata  = act ? wd : 32'h0;
  assign mem_wr     = state == WR;
  assign busy       = state == RD || state == WT || state == WR;
  assign done       = state == FIN;
  assign misaligned = state == ERR;
endmodule

// File: tb/tb_store_size_ctrl.sv
// tb_store_size_ctrl: two DUTs (WAIT_CYCLES 1 and 3) fed identical requests, checked by a byte-level model.
module tb_store_size_ctrl;
  localparam int W0 = 1, W1 = 3;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0]  ss_op = 0;
  logic [31:0] addr = 0, reg_data = 0;
  logic [31:0] mem_rdata [2], mem_addr [2], mem_wdata [2];
  logic        mem_wr [2], busy [2], done [2], misaligned [2];
  typedef struct {bit err; bit sw; logic [31:0] wa; logic [31:0] wd; int t0;} item_t;
  item_t       exp_q[$];
  int          ptr [2] = '{0, 0};
  int          k [2] = '{0, 0};
  bit          fin [2];
  logic [31:0] last_wd [2];
  logic [31:0] dmem [2][256];
  logic [7:0]  rb [1024];
  int errors = 0, checks = 0, cyc = 0;
  store_size_ctrl #(.ADDR_W(32), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .ss_op(ss_op), .addr(addr), .reg_data(reg_data),
    .mem_rdata(mem_rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wr(mem_wr[0]),
    .busy(busy[0]), .done(done[0]), .misaligned(misaligned[0]));
  store_size_ctrl #(.ADDR_W(32), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ss_op(ss_op), .addr(addr), .reg_data(reg_data),
    .mem_rdata(mem_rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wr(mem_wr[1]),
    .busy(busy[1]), .done(done[1]), .misaligned(misaligned[1]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Read data is only valid in the cycle WAIT_CYCLES after the address appeared; otherwise it is poisoned.
  assign mem_rdata[0] = (k[0] == W0 + 1) ? dmem[0][mem_addr[0][9:2]] : ~dmem[0][mem_addr[0][9:2]];
  assign mem_rdata[1] = (k[1] == W1 + 1) ? dmem[1][mem_addr[1][9:2]] : ~dmem[1][mem_addr[1][9:2]];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask
  task automatic stray(input string name, input int g);
    checks++;
    errors++;
    $display("FAIL %s dut%0d: got pulse required none", name, g);
  endtask
  always @(negedge clk) begin
    item_t it;
    int wl;
    if (reset) k = '{0, 0};
    else for (int g = 0; g < 2; g++) begin
      wl = g == 0 ? W0 : W1;
      if (mem_wr[g]) begin
        if (ptr[g] >= exp_q.size()) stray("unexpected_wr", g);
        else begin
          it = exp_q[ptr[g]];
          chk($sformatf("wr_kind dut%0d", g), 32'(it.err), 32'd0);
          chk($sformatf("wr_addr dut%0d", g), mem_addr[g], it.wa);
          chk($sformatf("wr_data dut%0d", g), mem_wdata[g], it.wd);
          chk($sformatf("wr_cycle dut%0d", g), 32'(cyc - it.t0), 32'(it.sw ? 1 : 2 + wl));
          chk($sformatf("wr_busy dut%0d", g), 32'(busy[g]), 32'd1);
          last_wd[g] = mem_wdata[g];
          dmem[g][mem_addr[g][9:2]] = mem_wdata[g];
        end
      end
      if (done[g]) begin
        if (ptr[g] >= exp_q.size()) stray("unexpected_done", g);
        else begin
          it = exp_q[ptr[g]];
          chk($sformatf("done_kind dut%0d", g), 32'(it.err), 32'd0);
          chk($sformatf("done_cycle dut%0d", g), 32'(cyc - it.t0), 32'(it.sw ? 2 : 3 + wl));
          chk($sformatf("done_busy dut%0d", g), 32'(busy[g]), 32'd0);
          chk($sformatf("done_addr_hold dut%0d", g), mem_addr[g], it.wa);
          ptr[g]++;
          fin[g] = 1;
        end
      end
      if (misaligned[g]) begin
        if (ptr[g] >= exp_q.size()) stray("unexpected_misaligned", g);
        else begin
          it = exp_q[ptr[g]];
          chk($sformatf("err_kind dut%0d", g), 32'(it.err), 32'd1);
          chk($sformatf("err_cycle dut%0d", g), 32'(cyc - it.t0), 32'd1);
          chk($sformatf("err_flags dut%0d", g), {30'b0, done[g], mem_wr[g]}, 32'd0);
          ptr[g]++;
          fin[g] = 1;
        end
      end
      k[g] = (busy[g] && !mem_wr[g]) ? k[g] + 1 : 0;
    end
  end
  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) rb[{a[9:2], 2'b00} + 10'(i)] = v[8*i +: 8];
    dmem[0][a[9:2]] = v;
    dmem[1][a[9:2]] = v;
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input int junk);
    item_t it;
    int bi, wi;
    @(negedge clk);
    bi = int'(a[9:0]);
    wi = bi & ~3;
    it.err = op == 2'd3 || (op == 2'd0 && a[1:0] != 2'd0) || (op == 2'd1 && a[0]);
    it.sw = op == 2'd0;
    it.t0 = cyc;
    it.wa = {a[31:2], 2'b00};
    it.wd = 32'h0;
    if (!it.err) begin
      for (int i = 0; i < (op == 2'd0 ? 4 : op == 2'd1 ? 2 : 1); i++) rb[bi + i] = d[8*i +: 8];
      it.wd = {rb[wi + 3], rb[wi + 2], rb[wi + 1], rb[wi]};
    end
    exp_q.push_back(it);
    fin = '{0, 0};
    ss_op = op; addr = a; reg_data = d; start = 1;
    @(negedge clk);
    ss_op = 2'($urandom); addr = $urandom; reg_data = $urandom;
    for (int c = 1; c < 40 && !(fin[0] && fin[1]); c++) begin
      start = c == junk;
      @(negedge clk);
      #1;
    end
    start = 0;
    if (!(fin[0] && fin[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout: got fin=%0d%0d required 11", fin[0], fin[1]);
    end
  endtask
  task automatic chk_idle(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s_addr dut%0d", tag, g), mem_addr[g], 32'h0);
      chk($sformatf("%s_wdata dut%0d", tag, g), mem_wdata[g], 32'h0);
      chk($sformatf("%s_flags dut%0d", tag, g), {28'b0, mem_wr[g], busy[g], done[g], misaligned[g]}, 32'h0);
    end
  endtask
  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      set_word(32'(i * 4), w);
    end
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 0;
    set_word(32'h100, 32'hDEADBEEF);
    issue(2'd2, 32'h102, 32'h123456AB, 0);
    chk("sb_102 dut0", last_wd[0], 32'hDEABBEEF);
    chk("sb_102 dut1", last_wd[1], 32'hDEABBEEF);
    set_word(32'h104, 32'h11223344);
    issue(2'd1, 32'h104, 32'h0000CAFE, 1);
    chk("sh_104", last_wd[1], 32'h1122CAFE);
    set_word(32'h104, 32'h11223344);
    issue(2'd1, 32'h106, 32'h0000CAFE, 1);
    chk("sh_106", last_wd[1], 32'hCAFE3344);
    issue(2'd0, 32'h108, 32'h89ABCDEF, 2);
    chk("sw_108", last_wd[0], 32'h89ABCDEF);
    issue(2'd0, 32'h10A, 32'h55555555, 1);
    issue(2'd1, 32'h101, 32'h66666666, 0);
    issue(2'd3, 32'h100, 32'h77777777, 0);
    set_word(32'h100, 32'h0);
    issue(2'd2, 32'h103, 32'h000000FF, 0);
    chk("sb_103 dut0", last_wd[0], 32'hFF000000);
    chk("sb_103 dut1", last_wd[1], 32'hFF000000);
    @(negedge clk);
    ss_op = 2'd2; addr = 32'h3F1; reg_data = 32'hA5; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk_idle("abort");
    repeat (6) @(negedge clk);
    issue(2'd2, 32'h3F1, 32'h5A, 0);
    for (int n = 0; n < 80; n++)
      issue(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 3)));
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("drained dut%0d", g), 32'(ptr[g]), 32'(exp_q.size()));
      for (int i = 0; i < 256; i++)
        chk($sformatf("mem[%0d] dut%0d", i, g), dmem[g][i], {rb[4*i + 3], rb[4*i + 2], rb[4*i + 1], rb[4*i]});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
